// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sequencer: datapath width, legal calculator
// modes and the sequencer state encoding.
package cordic_pkg;

  localparam int W = 64;

  localparam logic [2:0] MODE_CIRC_ROT = 3'b000;
  localparam logic [2:0] MODE_HYP_ROT  = 3'b001;
  localparam logic [2:0] MODE_CIRC_VEC = 3'b100;
  localparam logic [2:0] MODE_HYP_VEC  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP
  } cordic_seq_state_t;

  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode == MODE_CIRC_ROT) || (mode == MODE_HYP_ROT) ||
           (mode == MODE_CIRC_VEC) || (mode == MODE_HYP_VEC);
  endfunction

endpackage

// File: rtl/cordic_watchdog.sv
// Saturating RUN-cycle counter; expire_o flags the TIMEOUT-th consecutive enabled cycle.
// Latency: combinational flag from a registered count; no backpressure.
module cordic_watchdog #(
  parameter int TIMEOUT = 80
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The current cycle is counted, so the flag fires on the TIMEOUT-th RUN cycle.
  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cordic_seq.sv
// Drives the iterative CORDIC calculator: accept job, hold startr low LOAD_CYCLES, run to done, respond.
// Optional RUN timeout under `CORDIC_SEQ_TIMEOUT_EN`; a stalled response parks the calculator in load.
module cordic_seq #(
  parameter int W           = cordic_pkg::W,
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 80
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_mode,
  input  logic [W-1:0] req_z,
  input  logic [W-1:0] req_x,
  input  logic [W-1:0] req_y,
  input  logic [5:0]   req_iters,
  output logic [W-1:0] cal_z,
  output logic [W-1:0] cal_xx,
  output logic [W-1:0] cal_yy,
  output logic [2:0]   cal_mode,
  output logic [5:0]   cal_dur,
  output logic         cal_startr,
  input  logic [W-1:0] cal_xo,
  input  logic [W-1:0] cal_yo,
  input  logic [W-1:0] cal_zo,
  input  logic         cal_done,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_x,
  output logic [W-1:0] rsp_y,
  output logic [W-1:0] rsp_z,
  output logic         rsp_err
);

  import cordic_pkg::*;

  localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  cordic_seq_state_t state_q;
  logic [LCW-1:0]    load_cnt_q;
  logic              req_ready_q, startr_q, rsp_valid_q, rsp_err_q;
  logic [W-1:0]      cal_z_q, cal_xx_q, cal_yy_q;
  logic [2:0]        cal_mode_q;
  logic [5:0]        cal_dur_q;
  logic [W-1:0]      rsp_x_q, rsp_y_q, rsp_z_q;
  logic              load_last, timeout_hit;

  assign load_last = (load_cnt_q == LCW'(LOAD_CYCLES - 1));

`ifdef CORDIC_SEQ_TIMEOUT_EN
  cordic_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    ((state_q == S_LOAD) && load_last),
    .en_i     (state_q == S_RUN),
    .expire_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      req_ready_q <= 1'b1;
      startr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cal_z_q     <= '0;
      cal_xx_q    <= '0;
      cal_yy_q    <= '0;
      cal_mode_q  <= '0;
      cal_dur_q   <= '0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      rsp_z_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid && req_ready_q) begin
          cal_z_q     <= req_z;
          cal_xx_q    <= req_x;
          cal_yy_q    <= req_y;
          cal_mode_q  <= req_mode;
          cal_dur_q   <= req_iters;
          req_ready_q <= 1'b0;
          load_cnt_q  <= '0;
          if (mode_legal(req_mode)) begin
            state_q <= S_LOAD;
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_z_q     <= '0;
          end
        end
        S_LOAD: begin
          // startr stays low here so the calculator latches the new operands.
          if (load_last) begin
            state_q  <= S_RUN;
            startr_q <= 1'b1;
          end else begin
            load_cnt_q <= load_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (cal_done) begin
            rsp_x_q     <= cal_xo;
            rsp_y_q     <= cal_yo;
            rsp_z_q     <= cal_zo;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            startr_q    <= 1'b0;
            state_q     <= S_RESP;
          end else if (timeout_hit) begin
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_z_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            startr_q    <= 1'b0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign cal_z      = cal_z_q;
  assign cal_xx     = cal_xx_q;
  assign cal_yy     = cal_yy_q;
  assign cal_mode   = cal_mode_q;
  assign cal_dur    = cal_dur_q;
  assign cal_startr = startr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_x      = rsp_x_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_cordic_seq.sv
// Bench for cordic_seq with a behavioural iterative calculator attached to the cal_* side.
// Timeout case runs only when CORDIC_SEQ_TIMEOUT_EN is defined.
module tb_cordic_seq;

  localparam int W  = 64;
  localparam int LC = 2;
  localparam int TO = 80;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [2:0]   req_mode;
  logic [W-1:0] req_z, req_x, req_y;
  logic [5:0]   req_iters;
  logic [W-1:0] cal_z, cal_xx, cal_yy;
  logic [2:0]   cal_mode;
  logic [5:0]   cal_dur;
  logic         cal_startr;
  logic [W-1:0] cal_xo, cal_yo, cal_zo;
  logic         cal_done;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_x, rsp_y, rsp_z;
  logic         rsp_err;

  cordic_seq #(.W(W), .LOAD_CYCLES(LC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_z(req_z), .req_x(req_x), .req_y(req_y), .req_iters(req_iters),
    .cal_z(cal_z), .cal_xx(cal_xx), .cal_yy(cal_yy), .cal_mode(cal_mode),
    .cal_dur(cal_dur), .cal_startr(cal_startr),
    .cal_xo(cal_xo), .cal_yo(cal_yo), .cal_zo(cal_zo), .cal_done(cal_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] x; logic [W-1:0] y; logic [W-1:0] z; } tri_t;
  typedef struct { logic [2:0] mode; logic [W-1:0] x, y, z; logic [5:0] it; logic err; } vec_t;
  typedef struct { logic [W-1:0] x, y, z; logic err; } exp_t;

  // One micro-rotation; the angle constant is a stand-in, the sequencer only relays results.
  function automatic tri_t step(input logic [2:0] m, input tri_t s, input int i);
    logic signed [W-1:0] x, y, z, ang, dx, dy;
    logic d;
    tri_t r;
    x   = $signed(s.x);
    y   = $signed(s.y);
    z   = $signed(s.z);
    ang = 64'sh1000_0000_0000_0000 >>> i;
    dx  = y >>> i;
    dy  = x >>> i;
    d   = m[2] ? y[W-1] : ~z[W-1];
    if (!d) begin dx = -dx; dy = -dy; ang = -ang; end
    r.x = m[0] ? x + dx : x - dx;
    r.y = y + dy;
    r.z = z - ang;
    return r;
  endfunction

  function automatic tri_t model(input vec_t v);
    tri_t s = '{v.x, v.y, v.z};
    for (int i = 0; i <= int'(v.it); i++) s = step(v.mode, s, i);
    return s;
  endfunction

  // Behavioural calculator: reloads while startr is low, iterates 0..dur while high.
  tri_t       cs;
  logic [5:0] cit;
  logic       cdone, calc_hang;
  always @(posedge clk) begin
    if (!cal_startr) begin
      cs    <= '{cal_xx, cal_yy, cal_z};
      cit   <= '0;
      cdone <= 1'b0;
    end else if (!cdone && !calc_hang) begin
      cs <= step(cal_mode, cs, int'(cit));
      if (cit == cal_dur) cdone <= 1'b1;
      else cit <= cit + 1'b1;
    end
  end
  assign cal_xo = cs.x;
  assign cal_yo = cs.y;
  assign cal_zo = cs.z;
  assign cal_done = cdone;

  int   n_cmp = 0, n_fail = 0;
  exp_t sb[$];
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic accept(input vec_t v, output int waited);
    bit   ok = 0;
    tri_t r;
    waited = 0;
    req_mode = v.mode; req_x = v.x; req_y = v.y; req_z = v.z; req_iters = v.it;
    req_valid = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      if (req_ready) ok = 1;
      else begin waited++; @(posedge clk); #1; end
    end
    if (ok) begin
      @(posedge clk); #1;
      if (v.err) sb.push_back('{'0, '0, '0, 1'b1});
      else begin r = model(v); sb.push_back('{r.x, r.y, r.z, 1'b0}); end
    end else chk("accept_timeout", 64'(ok), 64'(1));
    req_valid = 1'b0;
  endtask

  task automatic collect(input vec_t v, input int exp_rk, input int exp_sk);
    int   st_k = -1, rk = -1;
    exp_t e;
    for (int k = 0; k < 400 && rk < 0; k++) begin
      if (cal_startr && st_k < 0) st_k = k;
      if (rsp_valid) rk = k;
      else begin @(posedge clk); #1; end
    end
    chk("rsp_latency", 64'(rk), 64'(exp_rk));
    chk("startr_rise", 64'(st_k), 64'(exp_sk));
    chk("cal_operands", {cal_xx ^ cal_yy ^ cal_z}, v.x ^ v.y ^ v.z);
    chk("cal_mode_dur", {55'd0, cal_mode, cal_dur}, {55'd0, v.mode, v.it});
    if (rk >= 0) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'(1));
      else begin
        e = sb.pop_front();
        chk("rsp_x", rsp_x, e.x);
        chk("rsp_y", rsp_y, e.y);
        chk("rsp_z", rsp_z, e.z);
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'(0));
    chk("req_ready_back", 64'(req_ready), 64'(1));
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    accept(v, w);
    chk("req_ready_busy", 64'(req_ready), 64'(0));
    collect(v, v.err ? 0 : LC + int'(v.it) + 2, v.err ? -1 : LC);
    handshake();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    vec_t a, b;
    int   w, bad;
    logic [W-1:0] hx, hy, hz;
    logic hv;

    tbl[0] = '{3'b000, 64'h1000_0000_0000_0000, 64'd0, 64'd0, 6'd40, 1'b0};
    tbl[1] = '{3'b101, 64'h1000_0000_0000_0000, 64'h0800_0000_0000_0000, 64'd0, 6'd50, 1'b0};
    tbl[2] = '{3'b100, 64'h0C00_0000_0000_0000, 64'hFC00_0000_0000_0000, 64'd0, 6'd30, 1'b0};
    tbl[3] = '{3'b001, 64'h1000_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h0400_0000_0000_0000, 6'd20, 1'b0};
    tbl[4] = '{3'b000, 64'd12345, 64'hFFFF_FFFF_FFFF_FC19, 64'hF800_0000_0000_0000, 6'd0, 1'b0};
    tbl[5] = '{3'b100, 64'hFFFC_0000_0000_0000, 64'h0007_0000_0000_0000, 64'd5, 6'd63, 1'b0};
    tbl[6] = '{3'b010, 64'h1000_0000_0000_0000, 64'd7, 64'd9, 6'd10, 1'b1};
    tbl[7] = '{3'b111, 64'd1, 64'd2, 64'd3, 6'd63, 1'b1};
    tbl[8] = '{3'b011, 64'hDEAD_BEEF, 64'hCAFE, 64'h55, 6'd0, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; calc_hang = 1'b0;
    req_mode = '0; req_x = '0; req_y = '0; req_z = '0; req_iters = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_startr", 64'(cal_startr), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_cal_ops", cal_xx | cal_yy | cal_z | 64'(cal_mode) | 64'(cal_dur), 64'd0);
    chk("rst_rsp_data", rsp_x | rsp_y | rsp_z, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Backpressure: response held 20 cycles while a second job waits.
    a = tbl[1];
    b = tbl[3];
    accept(a, w);
    collect(a, LC + int'(a.it) + 2, LC);
    hx = rsp_x; hy = rsp_y; hz = rsp_z; hv = rsp_err;
    req_mode = b.mode; req_x = b.x; req_y = b.y; req_z = b.z; req_iters = b.it;
    req_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_x !== hx || rsp_y !== hy || rsp_z !== hz || rsp_err !== hv || rsp_valid !== 1'b1 ||
          req_ready !== 1'b0 || cal_startr !== 1'b0 || cal_xx !== a.x) bad++;
    end
    chk("stall_stable", 64'(bad), 64'(0));
    handshake();
    accept(b, w);
    chk("b2b_accept_wait", 64'(w), 64'(0));
    collect(b, LC + int'(b.it) + 2, LC);
    handshake();

    // Reset while the calculator is mid-RUN.
    a = '{3'b000, 64'h0800_0000_0000_0000, 64'd0, 64'h0123_4567_89AB_CDEF, 6'd60, 1'b0};
    accept(a, w);
    repeat (10) begin @(posedge clk); #1; end
    chk("pre_rst_running", 64'(cal_startr), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_startr", 64'(cal_startr), 64'(0));
    chk("mid_rst_req_ready", 64'(req_ready), 64'(1));
    chk("mid_rst_rsp", {63'd0, rsp_valid} | {63'd0, rsp_err} | rsp_x | rsp_y | rsp_z, 64'd0);
    chk("mid_rst_cal_ops", cal_xx | cal_yy | cal_z | 64'(cal_mode) | 64'(cal_dur), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
    run_vec(tbl[2]);

`ifdef CORDIC_SEQ_TIMEOUT_EN
    calc_hang = 1'b1;
    a = '{3'b001, 64'h1000_0000_0000_0000, 64'd3, 64'd4, 6'd5, 1'b1};
    accept(a, w);
    collect(a, LC + TO, LC);
    handshake();
    calc_hang = 1'b0;
    run_vec(tbl[0]);
`endif

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_seq.md
# cordic_seq

Request/response sequencer that drives the iterative CORDIC `calculator` from its initiator side. It accepts one job per valid/ready handshake and loads the job's operands, mode and iteration count onto the calculator. It then controls `startr`, waits for `done`, captures `Xo/Yo/Zo` and returns them on a valid/ready response channel. It sits between the system bus/command logic and the calculator; a wrapper instantiates both and wires the `cal_*` ports.

## Interface
Parameters:
- W, 64, datapath width; must equal calculator width.
- LOAD_CYCLES, 2, cycles `cal_startr` is held low with new operands before starting; minimum 2.
- TIMEOUT, 80, cycles in RUN without `cal_done` before an error response; used only with `CORDIC_SEQ_TIMEOUT_EN`.

Ports:
- clk, in, 1, sole clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, job present.
- req_ready, out, 1, job accepted when both are high.
- req_mode, in, 3, calculator mode.
- req_z / req_x / req_y, in, W each, operands.
- req_iters, in, 6, last iteration index; driven to `cal_dur`.
- cal_z / cal_xx / cal_yy, out, W each, operands to the calculator.
- cal_mode, out, 3, mode to the calculator.
- cal_dur, out, 6, iteration count to the calculator.
- cal_startr, out, 1, calculator start level.
- cal_xo / cal_yo / cal_zo, in, W each, calculator results.
- cal_done, in, 1, calculator completion level.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, response consumed when both are high.
- rsp_x / rsp_y / rsp_z, out, W each, results.
- rsp_err, out, 1, illegal mode, or timeout.

## Operation
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - `req_ready`=1 and `cal_startr`=0.
  - On handshake: register mode, operands and iters onto the `cal_*` outputs.
  - Legal modes are 000, 001, 100 and 101. A legal mode goes to LOAD with the load counter cleared.
  - Any other mode goes straight to RESP with `rsp_err`=1 and `rsp_x/y/z`=0; the calculator is not started.
- LOAD:
  - `cal_startr`=0 for LOAD_CYCLES cycles. This guarantees the calculator samples start low and latches its initial state from the `cal_*` values.
  - Then go to RUN.
- RUN:
  - `cal_startr`=1.
  - On the first cycle `cal_done` is sampled high: capture `cal_xo/yo/zo` into `rsp_x/y/z`, set `rsp_err`=0 and go to RESP.
- RESP:
  - `rsp_valid`=1.
  - `cal_startr`=0, which clears the calculator's done flag.
  - On `rsp_ready` go to IDLE.
- `cal_*` operand outputs hold their value from acceptance until the next acceptance.
- `rsp_x/y/z/err` are stable while `rsp_valid`=1.
- A `cal_done` seen outside RUN is ignored.
- Stalling: `rsp_ready` may stay low indefinitely. The sequencer waits in RESP with `cal_startr` low, so the calculator sits in its load branch.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - State returns to IDLE.
  - `req_ready`=1.
  - `cal_startr`=0.
  - `rsp_valid`=0 and `rsp_err`=0.
  - `cal_z/xx/yy/mode/dur` and `rsp_x/y/z` are all 0.
  - An in-flight job is discarded with no response. The calculator needs no reset: startr low reloads it.
- Acceptance at edge T:
  - LOAD covers cycles T+1..T+LOAD_CYCLES.
  - `cal_startr` rises at T+LOAD_CYCLES+1.
  - `rsp_valid` rises on the cycle after `cal_done` is first sampled high.
- Illegal mode: `rsp_valid` rises at T+1.
- Back-to-back: `req_ready` returns the cycle after the response handshake. A request pending during RESP is accepted on that cycle.
- `req_iters`=0 is legal: single iteration.
- `req_iters`=63 is the maximum.

## Configuration
- `CORDIC_SEQ_TIMEOUT_EN` defined:
  - A RUN-cycle counter saturates at TIMEOUT.
  - On reaching TIMEOUT without `cal_done`: go to RESP with `rsp_err`=1 and `rsp_x/y/z`=0.
  - The counter clears on entering RUN.
- Undefined: no counter; RUN waits for `cal_done` indefinitely.

## Structure
- Shared package `cordic_pkg` contains:
  - W.
  - Mode constants: MODE_CIRC_ROT=000, MODE_HYP_ROT=001, MODE_CIRC_VEC=100, MODE_HYP_VEC=101.
  - Function `mode_legal()`.
  - State enum `cordic_seq_state_t`.
- One natural sub-module: `cordic_watchdog`, the saturating timeout counter, instantiated only under `CORDIC_SEQ_TIMEOUT_EN`.
- The calculator is not instantiated here.

## Test plan
- Circular rotation: mode 000, z=0, iters=40 → `cal_startr` rises 3 cycles after acceptance; `rsp_y`=Yo from the bench calculator model (≈0); `rsp_err`=0.
- Hyperbolic vectoring: mode 101, x=2^60, y=2^59, iters=50 → `rsp_x/y/z` equal model Xo/Yo/Zo; one response per request.
- Illegal mode 010 → `rsp_valid` at T+1, `rsp_err`=1, results 0, `cal_startr` never high.
- Backpressure: hold `rsp_ready` low 20 cycles with a second request pending → results stable, `req_ready` low; second job accepted the cycle after the handshake and returns correct results.
- Reset mid-RUN (iters=60, `rst_n` low at cycle 10) → all outputs at reset values immediately; a new job completes correctly.
- `CORDIC_SEQ_TIMEOUT_EN`, calculator stub never asserting done, TIMEOUT=80 → `rsp_err`=1 after 80 RUN cycles.
